// File: rtl/hilo_mult_unit.sv
// Iterative shift-add mult/multu unit with architectural HI/LO registers.
// Optional early termination when the multiplier runs out: MULT_EARLY_TERM_EN.
module hilo_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [4:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             WriteHi,
    input  logic             WriteLo,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [4:0] OP_MULT  = 5'b00010;
    localparam logic [4:0] OP_MULTU = 5'b01101;
    localparam int         CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LASTC = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               neg;

    logic               is_mult;
    logic               op_ok;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   mplier_nx;
    logic               last;

    assign is_mult   = (ALUOp == OP_MULT);
    assign op_ok     = is_mult || (ALUOp == OP_MULTU);
    assign a_mag     = (is_mult && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign b_mag     = (is_mult && B[WIDTH-1]) ? (~B + 1'b1) : B;
    assign mplier_nx = mplier >> 1;

`ifdef MULT_EARLY_TERM_EN
    // Remaining multiplier bits all zero: further iterations add nothing.
    assign last = (count == LASTC) || (mplier_nx == '0);
`else
    assign last = (count == LASTC);
`endif

    assign Busy = (state != IDLE);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            neg    <= 1'b0;
            HI     <= '0;
            LO     <= '0;
            Done   <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start && op_ok) begin
                        mplier <= b_mag;
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        acc    <= '0;
                        count  <= '0;
                        neg    <= is_mult && (A[WIDTH-1] ^ B[WIDTH-1]);
                        state  <= RUN;
                    end else if (!Start) begin
                        if (WriteHi) HI <= A;
                        if (WriteLo) LO <= A;
                    end
                end
                RUN: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier_nx;
                    count  <= count + 1'b1;
                    if (last) state <= FINISH;
                end
                FINISH: begin
                    {HI, LO} <= neg ? (~acc + 1'b1) : acc;
                    Done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
- Multi-cycle execute-stage unit that consumes the 5-bit ALUOp codes for mult (00010) and multu (01101) produced by the ALU control decode.
- Computes the full 2*WIDTH-bit product with an iterative shift-add datapath and holds the result in architectural HI/LO registers.
- Also services mthi/mtlo writes through dedicated strobes, because ALUOp 10101 is shared with movn/movz.
- The pipeline stalls on Busy.

Parameters:
- WIDTH, 32, operand width and HI/LO register width.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Start  in  1  request a multiply using ALUOp, A and B; sampled only in IDLE.
- ALUOp  in  5  operation code: 00010 = signed mult, 01101 = unsigned multu; any other code is ignored.
- A  in  WIDTH  rs operand; also the data source for WriteHi/WriteLo.
- B  in  WIDTH  rt operand.
- WriteHi  in  1  mthi strobe: HI <= A.
- WriteLo  in  1  mtlo strobe: LO <= A.
- Busy  out  1  high whenever state != IDLE.
- Done  out  1  one-cycle pulse; HI/LO hold the new product in the same cycle.
- HI  out  WIDTH  upper product word.
- LO  out  WIDTH  lower product word.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state = IDLE; HI = LO = 0; Busy = 0; Done = 0.
  - Internal accumulator, multiplicand, multiplier and counter cleared.
- States: IDLE, RUN, FINISH.
- IDLE, on an edge where Start=1 and ALUOp is 00010 or 01101:
  - Latch mplier = |B| and mcand = zero-extended |A| (2*WIDTH bits); clear acc (2*WIDTH bits) and count.
  - For signed: |x| is the two's-complement magnitude, treated as unsigned (|0x80000000| = 0x80000000). neg = A[W-1]^B[W-1].
  - For unsigned: operands taken as-is; neg = 0.
  - Go to RUN.
- IDLE with Start=1 and any other ALUOp: ignored; no state change; HI/LO untouched.
- IDLE with Start=0:
  - WriteHi=1 → HI <= A; WriteLo=1 → LO <= A.
  - Both strobes high → both registers written with A.
- Start and WriteHi/WriteLo on the same edge with a valid ALUOp: Start wins; writes discarded.
- RUN, each edge:
  - if mplier[0]: acc <= acc + mcand.
  - mcand <<= 1; mplier >>= 1; count <= count + 1.
  - After the iteration with count == WIDTH-1 → FINISH. Exactly WIDTH iterations.
- FINISH, one edge:
  - {HI, LO} <= neg ? -acc : acc, using 2*WIDTH-bit two's-complement negation.
  - Done <= 1 for exactly the following cycle; state <= IDLE.
- Latency: Start sampled at edge 0; iterations at edges 1..WIDTH; HI/LO and Done update at edge WIDTH+1. Busy is high from edge 0 through edge WIDTH+1.
- While Busy:
  - Start, WriteHi and WriteLo are ignored.
  - HI/LO keep their previous values until FINISH.
- Back-to-back: Start may be asserted in the cycle Done is high (state already IDLE) and is accepted.
- Arithmetic is modulo 2^(2*WIDTH); no overflow flag.

Optional Feature:
- Macro MULT_EARLY_TERM_EN.
- When defined, RUN also exits to FINISH after any iteration in which the updated mplier == 0. This gives minimum latency of 2 edges from Start to the Done-producing edge (1 iteration + FINISH). Results are identical to the full iteration.
- When undefined, RUN always performs exactly WIDTH iterations, giving fixed latency WIDTH+1.

Test Plan:
- multu A=7, B=6 (WIDTH=32) → Busy high from edge 0 to edge 33; Done pulse in the cycle after edge 33; HI=0x00000000, LO=0x0000002A.
- mult A=0xFFFFFFFD (-3), B=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- mult A=B=0x80000000 → HI=0x40000000, LO=0. multu A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- Idle writes:
  - WriteHi with A=0x12345678 → HI=0x12345678.
  - WriteLo with A=0x9ABCDEF0 → LO=0x9ABCDEF0.
  - Start with ALUOp=00000 → Busy stays 0; HI/LO unchanged.
  - WriteHi asserted mid-multiply → ignored; HI gets the product at FINISH.
- Reset mid-operation: Rst pulsed after the 10th iteration of multu 0xFFFF×0xFFFF → Busy=0, HI=LO=0 immediately. A following multu 3×4 → LO=12 with full normal latency.
- With MULT_EARLY_TERM_EN, multu A=5, B=1 → Done-producing edge is edge 2, LO=5. Without the macro → edge 33, LO=5.
